// File: rtl/main_memory_responder_if.sv
// Memory-side request bus between the cache controller (master) and the
// backing memory responder (slave).
interface main_memory_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  mem_busy;
  logic [CNT_WIDTH-1:0]  rd_count;
  logic [CNT_WIDTH-1:0]  wr_count;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_busy, rd_count, wr_count
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_busy, rd_count, wr_count
  );
endinterface

// File: rtl/main_memory_responder.sv
// Word-addressed backing memory with fixed access latency, a one-cycle
// ready pulse per request, and wrapping read/write transaction counters.
module main_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  main_memory_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  // Array is deliberately not reset; benches preload/inspect it by hierarchy.
  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  state_t                r_state, w_next;
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ready;
  logic                  r_busy;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic                  w_capture;
  logic                  w_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      IDLE: if (bus.mem_req) begin
        w_capture = 1'b1;
        w_next    = BUSY;
      end
      BUSY: if (r_cnt == 8'd0) begin
        w_commit = 1'b1;
        w_next   = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_addr  <= bus.mem_addr;
        r_we    <= bus.mem_we;
        r_wdata <= bus.mem_wdata;
        r_cnt   <= LAT_M1;
        r_busy  <= 1'b1;
      end
      if (r_state == BUSY && r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
      if (w_commit) begin
        r_ready <= 1'b1;
        if (r_we) r_wr_cnt <= r_wr_cnt + 1'b1;
        else begin
          r_rdata  <= mem[r_addr];
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
      if (r_state == RESP) begin
        r_ready <= 1'b0;
        r_busy  <= 1'b0;
      end
    end
  end

  // Commit is gated by the FSM, which reset forces to IDLE, so an aborted
  // transaction never lands in the array.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && r_we)
      mem[r_addr] <= r_wdata;
  end

  assign bus.mem_rdata = r_rdata;
  assign bus.mem_ready = r_ready;
  assign bus.mem_busy  = r_busy;
  assign bus.rd_count  = r_rd_cnt;
  assign bus.wr_count  = r_wr_cnt;
endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: directed and random transactions checked
// against an associative-array memory model with simple counters.
module tb_main_memory_responder;
  localparam int AW = 16, DW = 32, CW = 16, LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_memory_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus_a ();
  main_memory_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(8),  .CNT_WIDTH(4))  bus_b ();

  main_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  main_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(8), .LATENCY(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int checks = 0, failures = 0;
  int pulses_a = 0, pulses_b = 0, cyc = 0;

  // Reference model: sparse memory defaulting to the address, plus counters.
  logic [31:0] ref_mem [int];
  logic [15:0] exp_rd = '0, exp_wr = '0;
  logic [31:0] exp_rdata = '0;
  int          exp_pulses = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus_a.mem_ready === 1'b1) pulses_a++;
    if (bus_b.mem_ready === 1'b1) pulses_b++;
  end

  function automatic logic [31:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xact_a(input bit we, input logic [15:0] a, input logic [31:0] d, input bit scramble);
    int edges;
    bit seen;
    logic [31:0] old;
    old = ref_rd(int'(a));
    @(negedge clk);
    bus_a.mem_req = 1'b1; bus_a.mem_we = we; bus_a.mem_addr = a; bus_a.mem_wdata = d;
    @(posedge clk); #1;
    chk("busy_after_capture", 64'(bus_a.mem_busy), 64'd1);
    chk("mem_before_commit", 64'(dut_a.mem[a]), 64'(old));
    if (scramble) begin
      @(negedge clk);
      bus_a.mem_addr = 16'h4000; bus_a.mem_wdata = $urandom; bus_a.mem_we = ~we; bus_a.mem_req = 1'b0;
    end
    edges = 0; seen = 0;
    while (!seen && edges < 300) begin
      @(posedge clk); #1;
      edges++;
      if (bus_a.mem_ready === 1'b1) seen = 1;
    end
    if (we) begin
      ref_mem[int'(a)] = d;
      exp_wr++;
    end else begin
      exp_rdata = old;
      exp_rd++;
    end
    exp_pulses++;
    chk("ready_latency", 64'(edges), 64'(LAT));
    chk("rdata", 64'(bus_a.mem_rdata), 64'(exp_rdata));
    chk("rd_count", 64'(bus_a.rd_count), 64'(exp_rd));
    chk("wr_count", 64'(bus_a.wr_count), 64'(exp_wr));
    chk("mem_after_commit", 64'(dut_a.mem[a]), 64'(ref_rd(int'(a))));
    @(negedge clk);
    bus_a.mem_req = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", 64'(bus_a.mem_ready), 64'd0);
    chk("busy_cleared", 64'(bus_a.mem_busy), 64'd0);
  endtask

  initial begin
    int edges;
    bit seen;
    int rt [0:16];
    int p0;
    bus_a.mem_req = 1'b0; bus_a.mem_we = 1'b0; bus_a.mem_addr = '0; bus_a.mem_wdata = '0;
    bus_b.mem_req = 1'b0; bus_b.mem_we = 1'b0; bus_b.mem_addr = '0; bus_b.mem_wdata = '0;
    for (int i = 0; i < 2**AW; i++) dut_a.mem[i] = 32'(i);
    for (int i = 0; i < 256; i++) dut_b.mem[i] = 32'(i);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus_a.mem_ready), 64'd0);
    chk("rst_busy", 64'(bus_a.mem_busy), 64'd0);
    chk("rst_rdata", 64'(bus_a.mem_rdata), 64'd0);
    chk("rst_counts", 64'({bus_a.rd_count, bus_a.wr_count}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    xact_a(1'b0, 16'h1000, 32'h0, 1'b0);
    xact_a(1'b1, 16'h5000, 32'hDEADBEEF, 1'b0);
    xact_a(1'b0, 16'h5000, 32'h0, 1'b0);
    xact_a(1'b0, 16'h2000, 32'h0, 1'b0);
    xact_a(1'b0, 16'h3000, 32'h0, 1'b0);
    xact_a(1'b1, 16'h0010, 32'h00001234, 1'b1);
    chk("scramble_untouched", 64'(dut_a.mem[16'h4000]), 64'h4000);

    for (int k = 0; k < 20; k++)
      xact_a(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
    chk("pulse_total", 64'(pulses_a), 64'(exp_pulses));

    // Abort a write two cycles into BUSY with reset.
    @(negedge clk);
    bus_a.mem_req = 1'b1; bus_a.mem_we = 1'b1; bus_a.mem_addr = 16'h0020; bus_a.mem_wdata = 32'hCAFEF00D;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; bus_a.mem_req = 1'b0;
    #1;
    exp_rd = '0; exp_wr = '0; exp_rdata = '0;
    p0 = pulses_a;
    chk("abort_outputs", 64'({bus_a.mem_ready, bus_a.mem_busy, bus_a.mem_rdata}), 64'd0);
    chk("abort_counts", 64'({bus_a.rd_count, bus_a.wr_count}), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_pulse", 64'(pulses_a), 64'(p0));
    chk("abort_no_write", 64'(dut_a.mem[16'h0020]), 64'h20);
    @(negedge clk) rst_n = 1'b1;
    xact_a(1'b0, 16'h0020, 32'h0, 1'b0);

    // Narrow counters and LATENCY=1 on the second instance.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      bus_b.mem_req = 1'b1; bus_b.mem_we = 1'b1; bus_b.mem_addr = 8'(k); bus_b.mem_wdata = 32'h100 + 32'(k);
      @(posedge clk);
      edges = 0; seen = 0;
      while (!seen && edges < 50) begin
        @(posedge clk); #1;
        edges++;
        if (bus_b.mem_ready === 1'b1) seen = 1;
      end
      rt[k] = cyc;
      chk("b_latency", 64'(edges), 64'd1);
      @(negedge clk) bus_b.mem_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("b_period", 64'(rt[1] - rt[0]), 64'd3);
    chk("b_wr_wrap", 64'(bus_b.wr_count), 64'd1);
    chk("b_rd_count", 64'(bus_b.rd_count), 64'd0);
    chk("b_mem16", 64'(dut_b.mem[16]), 64'h110);
    chk("b_pulses", 64'(pulses_b), 64'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
